// File: rtl/easyaxi_rd_arb_pkg.sv
// Shared widths, FSM state encoding and constants for the EASYAXI read arbiter.
package easyaxi_rd_arb_pkg;

  localparam int AXI_ID_W    = 4;
  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_DATA_W  = 32;
  localparam int AXI_RESP_W  = 2;

  // Increment step for the beat counter; the counter wraps at its own width.
  localparam logic [AXI_LEN_W-1:0] LEN_ONE = {{(AXI_LEN_W-1){1'b0}}, 1'b1};

  // Burst ownership phases: waiting for a grant, forwarding AR, streaming R.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } arb_state_e;

endpackage

// File: rtl/easyaxi_rr_arb2.sv
// Two-way request arbiter: fixed priority (M0 first) or round-robin against the last owner.
module easyaxi_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       mode,
  output logic [1:0] gnt_oh
);

  // Select a single winner; on contention round-robin favours the master that did not own last.
  always_comb begin
    gnt_oh = 2'b00;
    case (req)
      2'b01: gnt_oh = 2'b01;
      2'b10: gnt_oh = 2'b10;
      2'b11: begin
        if (mode) begin
          gnt_oh = last_gnt ? 2'b01 : 2'b10;
        end else begin
          gnt_oh = 2'b01;
        end
      end
      default: gnt_oh = 2'b00;
    endcase
  end

endmodule

// File: rtl/easyaxi_rd_arb.sv
// 2:1 read-channel (AR + R) arbiter: one burst in flight, R steered to the owner until RLAST.
module easyaxi_rd_arb
  import easyaxi_rd_arb_pkg::*;
#(
  parameter int ARB_MODE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   m0_arvalid,
  output logic                   m0_arready,
  input  logic [AXI_ID_W-1:0]    m0_arid,
  input  logic [AXI_ADDR_W-1:0]  m0_araddr,
  input  logic [AXI_LEN_W-1:0]   m0_arlen,
  input  logic [AXI_SIZE_W-1:0]  m0_arsize,
  input  logic [AXI_BURST_W-1:0] m0_arburst,
  output logic                   m0_rvalid,
  input  logic                   m0_rready,
  output logic [AXI_ID_W-1:0]    m0_rid,
  output logic [AXI_DATA_W-1:0]  m0_rdata,
  output logic [AXI_RESP_W-1:0]  m0_rresp,
  output logic                   m0_rlast,
  input  logic                   m1_arvalid,
  output logic                   m1_arready,
  input  logic [AXI_ID_W-1:0]    m1_arid,
  input  logic [AXI_ADDR_W-1:0]  m1_araddr,
  input  logic [AXI_LEN_W-1:0]   m1_arlen,
  input  logic [AXI_SIZE_W-1:0]  m1_arsize,
  input  logic [AXI_BURST_W-1:0] m1_arburst,
  output logic                   m1_rvalid,
  input  logic                   m1_rready,
  output logic [AXI_ID_W-1:0]    m1_rid,
  output logic [AXI_DATA_W-1:0]  m1_rdata,
  output logic [AXI_RESP_W-1:0]  m1_rresp,
  output logic                   m1_rlast,
  output logic                   s_arvalid,
  input  logic                   s_arready,
  output logic [AXI_ID_W-1:0]    s_arid,
  output logic [AXI_ADDR_W-1:0]  s_araddr,
  output logic [AXI_LEN_W-1:0]   s_arlen,
  output logic [AXI_SIZE_W-1:0]  s_arsize,
  output logic [AXI_BURST_W-1:0] s_arburst,
  input  logic                   s_rvalid,
  output logic                   s_rready,
  input  logic [AXI_ID_W-1:0]    s_rid,
  input  logic [AXI_DATA_W-1:0]  s_rdata,
  input  logic [AXI_RESP_W-1:0]  s_rresp,
  input  logic                   s_rlast,
  output logic                   busy,
  output logic                   err_len
);

  localparam logic MODE_RR = (ARB_MODE != 0);

  arb_state_e             state_r, state_n;
  logic                   gnt_r, last_gnt_r;
  logic [AXI_LEN_W-1:0]   beat_cnt_r;
  logic [1:0]             win_oh_s;
  logic                   ar_acc_s, r_hs_s;
  logic                   s_arvalid_r, busy_r, err_len_r;
  logic [AXI_ID_W-1:0]    s_arid_r;
  logic [AXI_ADDR_W-1:0]  s_araddr_r;
  logic [AXI_LEN_W-1:0]   s_arlen_r;
  logic [AXI_SIZE_W-1:0]  s_arsize_r;
  logic [AXI_BURST_W-1:0] s_arburst_r;

  easyaxi_rr_arb2 u_arb (
    .req      ({m1_arvalid, m0_arvalid}),
    .last_gnt (last_gnt_r),
    .mode     (MODE_RR),
    .gnt_oh   (win_oh_s)
  );

  // R payload fans out to both masters; only the valid is steered.
  assign m0_rid   = s_rid;
  assign m0_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m0_rlast = s_rlast;
  assign m1_rid   = s_rid;
  assign m1_rdata = s_rdata;
  assign m1_rresp = s_rresp;
  assign m1_rlast = s_rlast;

  assign s_arvalid = s_arvalid_r;
  assign s_arid    = s_arid_r;
  assign s_araddr  = s_araddr_r;
  assign s_arlen   = s_arlen_r;
  assign s_arsize  = s_arsize_r;
  assign s_arburst = s_arburst_r;
  assign busy      = busy_r;
  assign err_len   = err_len_r;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next state, AR grant handshakes and R steering for the current owner.
  always_comb begin
    state_n    = state_r;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    s_rready   = 1'b0;
    ar_acc_s   = 1'b0;
    r_hs_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        m0_arready = win_oh_s[0];
        m1_arready = win_oh_s[1];
        if (win_oh_s != 2'b00) begin
          ar_acc_s = 1'b1;
          state_n  = ST_AR;
        end else begin
          state_n  = ST_IDLE;
        end
      end
      ST_AR: begin
        if (s_arvalid_r && s_arready) begin
          state_n = ST_R;
        end else begin
          state_n = ST_AR;
        end
      end
      ST_R: begin
        if (gnt_r) begin
          m1_rvalid = s_rvalid;
          s_rready  = m1_rready;
        end else begin
          m0_rvalid = s_rvalid;
          s_rready  = m0_rready;
        end
        r_hs_s = s_rvalid && s_rready;
        if (r_hs_s && s_rlast) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_R;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Grant bookkeeping, latched AR payload, beat counter and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r       <= 1'b0;
      last_gnt_r  <= 1'b1;
      beat_cnt_r  <= '0;
      s_arvalid_r <= 1'b0;
      busy_r      <= 1'b0;
      err_len_r   <= 1'b0;
      s_arid_r    <= '0;
      s_araddr_r  <= '0;
      s_arlen_r   <= '0;
      s_arsize_r  <= '0;
      s_arburst_r <= '0;
    end else begin
      s_arvalid_r <= (state_n == ST_AR);
      busy_r      <= (state_n != ST_IDLE);
      err_len_r   <= r_hs_s && (s_rlast ? (beat_cnt_r != s_arlen_r) : (beat_cnt_r == s_arlen_r));
      if (ar_acc_s) begin
        gnt_r       <= win_oh_s[1];
        s_arid_r    <= win_oh_s[1] ? m1_arid    : m0_arid;
        s_araddr_r  <= win_oh_s[1] ? m1_araddr  : m0_araddr;
        s_arlen_r   <= win_oh_s[1] ? m1_arlen   : m0_arlen;
        s_arsize_r  <= win_oh_s[1] ? m1_arsize  : m0_arsize;
        s_arburst_r <= win_oh_s[1] ? m1_arburst : m0_arburst;
      end else begin
        gnt_r <= gnt_r;
      end
      if ((state_r == ST_AR) && s_arvalid_r && s_arready) begin
        beat_cnt_r <= '0;
      end else if (r_hs_s) begin
        beat_cnt_r <= beat_cnt_r + LEN_ONE;
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
      if (r_hs_s && s_rlast) begin
        last_gnt_r <= gnt_r;
      end else begin
        last_gnt_r <= last_gnt_r;
      end
    end
  end

endmodule

// File: tb/tb_easyaxi_rd_arb.sv
// Bench for easyaxi_rd_arb: a fixed-priority and a round-robin instance, each with
// reactive masters/slave, a cycle-level burst model and directed literal expectations.
module tb_easyaxi_rd_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Index [k] selects the instance (0 = fixed priority, 1 = round-robin), [m] the master.
  logic        m_arvalid [2][2];
  logic        m_arready [2][2];
  logic [3:0]  m_arid    [2][2];
  logic [31:0] m_araddr  [2][2];
  logic [7:0]  m_arlen   [2][2];
  logic [2:0]  m_arsize  [2][2];
  logic [1:0]  m_arburst [2][2];
  logic        m_rvalid  [2][2];
  logic        m_rready  [2][2];
  logic [3:0]  m_rid     [2][2];
  logic [31:0] m_rdata   [2][2];
  logic [1:0]  m_rresp   [2][2];
  logic        m_rlast   [2][2];
  logic        s_arvalid [2];
  logic        s_arready [2];
  logic [3:0]  s_arid    [2];
  logic [31:0] s_araddr  [2];
  logic [7:0]  s_arlen   [2];
  logic [2:0]  s_arsize  [2];
  logic [1:0]  s_arburst [2];
  logic        s_rvalid  [2];
  logic        s_rready  [2];
  logic [3:0]  s_rid     [2];
  logic [31:0] s_rdata   [2];
  logic [1:0]  s_rresp   [2];
  logic        s_rlast   [2];
  logic        busy      [2];
  logic        err_len   [2];

  easyaxi_rd_arb #(.ARB_MODE(0)) dut_fx (
    .clk(clk), .rst_n(rst_n),
    .m0_arvalid(m_arvalid[0][0]), .m0_arready(m_arready[0][0]), .m0_arid(m_arid[0][0]),
    .m0_araddr(m_araddr[0][0]), .m0_arlen(m_arlen[0][0]), .m0_arsize(m_arsize[0][0]),
    .m0_arburst(m_arburst[0][0]), .m0_rvalid(m_rvalid[0][0]), .m0_rready(m_rready[0][0]),
    .m0_rid(m_rid[0][0]), .m0_rdata(m_rdata[0][0]), .m0_rresp(m_rresp[0][0]), .m0_rlast(m_rlast[0][0]),
    .m1_arvalid(m_arvalid[0][1]), .m1_arready(m_arready[0][1]), .m1_arid(m_arid[0][1]),
    .m1_araddr(m_araddr[0][1]), .m1_arlen(m_arlen[0][1]), .m1_arsize(m_arsize[0][1]),
    .m1_arburst(m_arburst[0][1]), .m1_rvalid(m_rvalid[0][1]), .m1_rready(m_rready[0][1]),
    .m1_rid(m_rid[0][1]), .m1_rdata(m_rdata[0][1]), .m1_rresp(m_rresp[0][1]), .m1_rlast(m_rlast[0][1]),
    .s_arvalid(s_arvalid[0]), .s_arready(s_arready[0]), .s_arid(s_arid[0]), .s_araddr(s_araddr[0]),
    .s_arlen(s_arlen[0]), .s_arsize(s_arsize[0]), .s_arburst(s_arburst[0]),
    .s_rvalid(s_rvalid[0]), .s_rready(s_rready[0]), .s_rid(s_rid[0]), .s_rdata(s_rdata[0]),
    .s_rresp(s_rresp[0]), .s_rlast(s_rlast[0]), .busy(busy[0]), .err_len(err_len[0])
  );

  easyaxi_rd_arb #(.ARB_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .m0_arvalid(m_arvalid[1][0]), .m0_arready(m_arready[1][0]), .m0_arid(m_arid[1][0]),
    .m0_araddr(m_araddr[1][0]), .m0_arlen(m_arlen[1][0]), .m0_arsize(m_arsize[1][0]),
    .m0_arburst(m_arburst[1][0]), .m0_rvalid(m_rvalid[1][0]), .m0_rready(m_rready[1][0]),
    .m0_rid(m_rid[1][0]), .m0_rdata(m_rdata[1][0]), .m0_rresp(m_rresp[1][0]), .m0_rlast(m_rlast[1][0]),
    .m1_arvalid(m_arvalid[1][1]), .m1_arready(m_arready[1][1]), .m1_arid(m_arid[1][1]),
    .m1_araddr(m_araddr[1][1]), .m1_arlen(m_arlen[1][1]), .m1_arsize(m_arsize[1][1]),
    .m1_arburst(m_arburst[1][1]), .m1_rvalid(m_rvalid[1][1]), .m1_rready(m_rready[1][1]),
    .m1_rid(m_rid[1][1]), .m1_rdata(m_rdata[1][1]), .m1_rresp(m_rresp[1][1]), .m1_rlast(m_rlast[1][1]),
    .s_arvalid(s_arvalid[1]), .s_arready(s_arready[1]), .s_arid(s_arid[1]), .s_araddr(s_araddr[1]),
    .s_arlen(s_arlen[1]), .s_arsize(s_arsize[1]), .s_arburst(s_arburst[1]),
    .s_rvalid(s_rvalid[1]), .s_rready(s_rready[1]), .s_rid(s_rid[1]), .s_rdata(s_rdata[1]),
    .s_rresp(s_rresp[1]), .s_rlast(s_rlast[1]), .busy(busy[1]), .err_len(err_len[1])
  );

  int checks = 0;
  int failures = 0;

  // Stimulus agents: pending requests per master, slave beats left to send.
  int          req_n    [2][2];
  logic [7:0]  req_len  [2][2];
  logic [31:0] req_addr [2][2];
  bit          rtog     [2][2];
  bit          rphase   [2];
  int          rem      [2];
  int          rbeat    [2];
  logic [3:0]  rid_cur  [2];
  int          sl_short [2];
  bit          nxt_arready [2];

  // Burst model: owner (-1 = none), AR still pending, beats received, captured request.
  int          own    [2];
  bit          arp    [2];
  int          nb     [2];
  bit          merr   [2];
  int          mlastg [2];
  logic [48:0] pay    [2];
  logic [7:0]  plen   [2];

  // Observations for literal expectations.
  int          glog     [2][16];
  int          gn       [2];
  bit          acc_prev [2];
  logic [31:0] aft_addr [2];
  logic        aft_vld  [2];
  int          bcnt     [2][2];
  int          ecnt     [2];

  task automatic chk(input int k, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL dut%0d %s actual=%0h required=%0h", k, nm, act, exp);
    end
  endtask

  // Per-cycle engine: model compare at negedge, agent reactions, then drive after posedge.
  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int m = 0; m < 2; m++) begin
        req_n[k][m] = 0; req_len[k][m] = 8'd0; req_addr[k][m] = 32'd0; rtog[k][m] = 1'b0;
        m_arvalid[k][m] = 1'b0; m_arid[k][m] = 4'd0; m_araddr[k][m] = 32'd0; m_arlen[k][m] = 8'd0;
        m_arsize[k][m] = 3'd0; m_arburst[k][m] = 2'd0; m_rready[k][m] = 1'b1; bcnt[k][m] = 0;
      end
      rphase[k] = 1'b1; rem[k] = 0; rbeat[k] = 0; rid_cur[k] = 4'd0; sl_short[k] = 0;
      nxt_arready[k] = 1'b0; s_arready[k] = 1'b0; s_rvalid[k] = 1'b0; s_rid[k] = 4'd0;
      s_rdata[k] = 32'd0; s_rresp[k] = 2'd0; s_rlast[k] = 1'b0;
      own[k] = -1; arp[k] = 1'b0; nb[k] = 0; merr[k] = 1'b0; mlastg[k] = 1; pay[k] = '0; plen[k] = 8'd0;
      gn[k] = 0; acc_prev[k] = 1'b0; aft_addr[k] = 32'd0; aft_vld[k] = 1'b0; ecnt[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        int w;
        bit idle;
        bit inr;
        bit orr;
        if (!rst_n) begin
          own[k] = -1; arp[k] = 1'b0; nb[k] = 0; merr[k] = 1'b0; mlastg[k] = 1; pay[k] = '0; plen[k] = 8'd0;
        end
        idle = (own[k] < 0);
        w = -1;
        if (idle) begin
          if (m_arvalid[k][0] && m_arvalid[k][1]) w = (k == 1 && mlastg[k] == 0) ? 1 : 0;
          else if (m_arvalid[k][0]) w = 0;
          else if (m_arvalid[k][1]) w = 1;
        end
        inr = !idle && !arp[k];
        orr = (own[k] == 1) ? m_rready[k][1] : m_rready[k][0];
        chk(k, "m0_arready", m_arready[k][0], w == 0);
        chk(k, "m1_arready", m_arready[k][1], w == 1);
        chk(k, "s_arvalid", s_arvalid[k], !idle && arp[k]);
        chk(k, "s_ar_payload", {s_arid[k], s_araddr[k], s_arlen[k], s_arsize[k], s_arburst[k]}, pay[k]);
        chk(k, "m0_rvalid", m_rvalid[k][0], inr && own[k] == 0 && s_rvalid[k]);
        chk(k, "m1_rvalid", m_rvalid[k][1], inr && own[k] == 1 && s_rvalid[k]);
        chk(k, "s_rready", s_rready[k], inr && orr);
        chk(k, "busy", busy[k], !idle);
        chk(k, "err_len", err_len[k], merr[k]);
        chk(k, "m0_r_payload", {m_rid[k][0], m_rdata[k][0], m_rresp[k][0], m_rlast[k][0]},
            {s_rid[k], s_rdata[k], s_rresp[k], s_rlast[k]});
        chk(k, "m1_r_payload", {m_rid[k][1], m_rdata[k][1], m_rresp[k][1], m_rlast[k][1]},
            {s_rid[k], s_rdata[k], s_rresp[k], s_rlast[k]});

        // Observations of what the DUT actually did.
        if (acc_prev[k]) begin
          aft_addr[k] = s_araddr[k];
          aft_vld[k]  = s_arvalid[k];
        end
        acc_prev[k] = 1'b0;
        for (int m = 0; m < 2; m++) begin
          if (m_arvalid[k][m] && m_arready[k][m]) begin
            if (gn[k] < 16) glog[k][gn[k]] = m;
            gn[k]++;
            acc_prev[k] = 1'b1;
          end
          if (m_rvalid[k][m] && m_rready[k][m]) bcnt[k][m]++;
        end
        if (err_len[k]) ecnt[k]++;

        // Advance the model across the coming clock edge.
        if (rst_n) begin
          merr[k] = 1'b0;
          if (idle) begin
            if (w >= 0) begin
              own[k] = w; arp[k] = 1'b1; plen[k] = m_arlen[k][w];
              pay[k] = {m_arid[k][w], m_araddr[k][w], m_arlen[k][w], m_arsize[k][w], m_arburst[k][w]};
            end
          end else if (arp[k]) begin
            if (s_arready[k]) begin
              arp[k] = 1'b0; nb[k] = 0;
            end
          end else if (s_rvalid[k] && orr) begin
            nb[k]++;
            if (s_rlast[k]) begin
              merr[k] = (nb[k] % 256) != ((int'(plen[k]) + 1) % 256);
              mlastg[k] = own[k];
              own[k] = -1;
            end else begin
              merr[k] = (nb[k] % 256) == ((int'(plen[k]) + 1) % 256);
            end
          end
        end

        // Agent reactions.
        if (!rst_n) begin
          req_n[k][0] = 0; req_n[k][1] = 0; rem[k] = 0; nxt_arready[k] = 1'b0;
        end else begin
          for (int m = 0; m < 2; m++) begin
            if (m_arvalid[k][m] && m_arready[k][m]) req_n[k][m]--;
          end
          if (s_arvalid[k] && s_arready[k]) begin
            rem[k] = (sl_short[k] > 0) ? sl_short[k] : int'(s_arlen[k]) + 1;
            rid_cur[k] = s_arid[k];
            rbeat[k] = 0;
          end
          nxt_arready[k] = s_arvalid[k] && !s_arready[k];
          if (s_rvalid[k] && s_rready[k]) begin
            rem[k]--;
            rbeat[k]++;
          end
        end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        rphase[k] = ~rphase[k];
        for (int m = 0; m < 2; m++) begin
          m_arvalid[k][m] = rst_n && (req_n[k][m] > 0);
          m_arid[k][m]    = m[3:0] + 4'd4;
          m_araddr[k][m]  = req_addr[k][m];
          m_arlen[k][m]   = req_len[k][m];
          m_arsize[k][m]  = 3'd2;
          m_arburst[k][m] = 2'd1;
          m_rready[k][m]  = rtog[k][m] ? rphase[k] : 1'b1;
        end
        s_arready[k] = nxt_arready[k];
        s_rvalid[k]  = (rem[k] > 0);
        s_rlast[k]   = (rem[k] == 1);
        s_rid[k]     = rid_cur[k];
        s_rdata[k]   = 32'hA000_0000 + 32'(k * 65536 + rbeat[k]);
        s_rresp[k]   = 2'(rbeat[k]);
      end
    end
  end

  task automatic queue_req(input int k, input int m, input int n, input logic [7:0] len, input logic [31:0] addr);
    req_len[k][m]  = len;
    req_addr[k][m] = addr;
    req_n[k][m]    = req_n[k][m] + n;
  endtask

  task automatic clr(input int k);
    gn[k] = 0; bcnt[k][0] = 0; bcnt[k][1] = 0; ecnt[k] = 0; aft_addr[k] = 32'd0; aft_vld[k] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int k, input string nm);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk); #2;
      done = (req_n[k][0] == 0) && (req_n[k][1] == 0) && (rem[k] == 0) && !busy[k];
    end
    chk(k, nm, done, 1'b1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  function automatic int gcode(input int k);
    int c = 0;
    for (int i = 0; i < gn[k] && i < 16; i++) c = c * 10 + glog[k][i] + 1;
    return c;
  endfunction

  // Directed scenarios with hand-computed expectations.
  initial begin
    bit got;
    repeat (3) @(posedge clk);
    #2;
    chk(1, "rst_busy", busy[1], 1'b0);
    chk(1, "rst_s_arvalid", s_arvalid[1], 1'b0);
    chk(1, "rst_s_araddr", s_araddr[1], 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Single M0 burst, arlen=3 at 0x100.
    clr(1);
    queue_req(1, 0, 1, 8'd3, 32'h100);
    wait_idle(1, "t1_idle");
    chk(1, "t1_aft_addr", aft_addr[1], 32'h100);
    chk(1, "t1_aft_vld", aft_vld[1], 1'b1);
    chk(1, "t1_beats_m0", bcnt[1][0], 4);
    chk(1, "t1_beats_m1", bcnt[1][1], 0);
    chk(1, "t1_err", ecnt[1], 0);
    chk(1, "t1_gcode", gcode(1), 1);

    // Round-robin: both masters request twice from reset -> M0,M1,M0,M1.
    do_reset();
    clr(1);
    queue_req(1, 0, 2, 8'd1, 32'h200);
    queue_req(1, 1, 2, 8'd1, 32'h300);
    wait_idle(1, "t2_idle");
    chk(1, "t2_grants", gn[1], 4);
    chk(1, "t2_order", gcode(1), 1212);
    chk(1, "t2_beats_m0", bcnt[1][0], 4);
    chk(1, "t2_beats_m1", bcnt[1][1], 4);

    // Fixed priority: M0 keeps requesting, M1 waits until M0 is done.
    clr(0);
    queue_req(0, 0, 3, 8'd0, 32'h280);
    queue_req(0, 1, 1, 8'd0, 32'h380);
    wait_idle(0, "t3_idle");
    chk(0, "t3_grants", gn[0], 4);
    chk(0, "t3_order", gcode(0), 1112);

    // M1 arlen=7 with rready toggling.
    do_reset();
    clr(1);
    rtog[1][1] = 1'b1;
    queue_req(1, 1, 1, 8'd7, 32'h400);
    wait_idle(1, "t4_idle");
    rtog[1][1] = 1'b0;
    chk(1, "t4_beats_m1", bcnt[1][1], 8);
    chk(1, "t4_err", ecnt[1], 0);

    // Early rlast on beat 2 of arlen=3.
    clr(1);
    sl_short[1] = 2;
    queue_req(1, 0, 1, 8'd3, 32'h500);
    wait_idle(1, "t5_idle");
    chk(1, "t5_err_pulses", ecnt[1], 1);
    chk(1, "t5_beats", bcnt[1][0], 2);

    // Overrun: 6 beats for arlen=3 -> flag at beat 4 and again at the late rlast.
    clr(1);
    sl_short[1] = 6;
    queue_req(1, 0, 1, 8'd3, 32'h540);
    wait_idle(1, "t5b_idle");
    sl_short[1] = 0;
    chk(1, "t5b_err_pulses", ecnt[1], 2);
    chk(1, "t5b_beats", bcnt[1][0], 6);

    // Reset during beat 2, then M0 wins the next contention.
    clr(1);
    queue_req(1, 1, 1, 8'd0, 32'h5C0);
    wait_idle(1, "t6_pre_idle");
    clr(1);
    queue_req(1, 0, 1, 8'd3, 32'h600);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #2;
      got = (bcnt[1][0] == 1);
    end
    chk(1, "t6_beat1_seen", got, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk(1, "t6_busy", busy[1], 1'b0);
    chk(1, "t6_s_arvalid", s_arvalid[1], 1'b0);
    chk(1, "t6_s_rready", s_rready[1], 1'b0);
    chk(1, "t6_m0_rvalid", m_rvalid[1][0], 1'b0);
    chk(1, "t6_err_len", err_len[1], 1'b0);
    chk(1, "t6_s_araddr", s_araddr[1], 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    clr(1);
    queue_req(1, 0, 1, 8'd0, 32'h700);
    queue_req(1, 1, 1, 8'd0, 32'h800);
    wait_idle(1, "t6_idle");
    chk(1, "t6_first_gnt", glog[1][0], 0);
    chk(1, "t6_order", gcode(1), 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
